// File: rtl/tetris_nios_mover_pkg.sv
// Shared types and helpers for the halfword fill/copy bus master.
package tetris_nios_mover_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_WAIT,
        ST_WR,
        ST_FIN
    } state_e;

    localparam logic [1:0]  BE_ALL     = 2'b11;
    localparam int unsigned ADDR_MAX_W = 32;

    // Words in the next copy chunk: never more than the buffer can hold.
    function automatic int unsigned chunk_words(input int unsigned chunk,
                                                input int unsigned remaining);
        return (remaining < chunk) ? remaining : chunk;
    endfunction

    function automatic logic [ADDR_MAX_W:0] hw_to_byte(input logic [ADDR_MAX_W-1:0] hw_addr);
        return {hw_addr, 1'b0};
    endfunction

endpackage

// File: rtl/tetris_nios_mover_fifo.sv
// Show-ahead chunk buffer holding read data until the write phase drains it.
module tetris_nios_mover_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [DATA_W-1:0]       rd_data_c,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_nxt_c;

    always_comb begin
        count_nxt_c = count;
        if (push && !pop)
            count_nxt_c = count + CNT_W'(1);
        else if (pop && !push)
            count_nxt_c = count - CNT_W'(1);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt_c;
            empty <= (count_nxt_c == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/tetris_nios_block_mover.sv
// Avalon-MM master that fills or chunk-copies runs of halfwords in on-chip RAM.
module tetris_nios_block_mover
    import tetris_nios_mover_pkg::*;
#(
    parameter int unsigned WADDR_W = 17,
    parameter int unsigned CHUNK   = 8,
    parameter int unsigned LEN_W   = 17
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_copy,
    input  logic [WADDR_W-1:0]   cmd_src,
    input  logic [WADDR_W-1:0]   cmd_dst,
    input  logic [LEN_W-1:0]     cmd_len,
    input  logic [15:0]          cmd_fill,
    output logic                 busy,
    output logic                 done,
    output logic [WADDR_W:0]     avm_address,
    output logic                 avm_read,
    output logic                 avm_write,
    output logic [15:0]          avm_writedata,
    output logic [1:0]           avm_byteenable,
    input  logic                 avm_waitrequest,
    input  logic [15:0]          avm_readdata,
    input  logic                 avm_readdatavalid
);

    localparam int unsigned          CNT_W   = $clog2(CHUNK) + 1;
    localparam logic [LEN_W-1:0]     LEN_ONE = LEN_W'(1);
    localparam logic [WADDR_W-1:0]   ADR_ONE = WADDR_W'(1);

    state_e               state;
    logic                 copy_mode;
    logic [WADDR_W-1:0]   src_addr;
    logic [WADDR_W-1:0]   dst_addr;
    logic [LEN_W-1:0]     remaining;
    logic [LEN_W-1:0]     n_words;
    logic [LEN_W-1:0]     rd_issued;
    logic [LEN_W-1:0]     rd_recv;
    logic [LEN_W-1:0]     wr_cnt;
    logic [15:0]          fill_val;

    logic                 fifo_push_c;
    logic                 fifo_pop_c;
    logic [15:0]          fifo_rd_data_c;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;

    logic                 rd_accept_c;
    logic                 wr_accept_c;
    logic                 rd_last_c;
    logic                 wr_last_c;
    logic [LEN_W-1:0]     recv_next_c;
    logic [LEN_W-1:0]     rem_after_c;
    logic [15:0]          wr_data_c;

    function automatic logic [WADDR_W:0] to_bus(input logic [WADDR_W-1:0] hw);
        return (WADDR_W+1)'(hw_to_byte(ADDR_MAX_W'(hw)));
    endfunction

    function automatic logic [LEN_W-1:0] chunk_n(input logic [LEN_W-1:0] rem);
        return LEN_W'(chunk_words(CHUNK, 32'(rem)));
    endfunction

    assign avm_byteenable = BE_ALL;

    assign rd_accept_c = avm_read  && !avm_waitrequest;
    assign wr_accept_c = avm_write && !avm_waitrequest;
    assign rd_last_c   = rd_accept_c && ((rd_issued + LEN_ONE) == n_words);
    assign wr_last_c   = wr_accept_c && ((wr_cnt + LEN_ONE) == n_words);
    // Beats are only meaningful while a chunk is being read; stragglers after reset are dropped.
    assign fifo_push_c = avm_readdatavalid && ((state == ST_RD) || (state == ST_RD_WAIT));
    assign fifo_pop_c  = (state == ST_WR) && copy_mode &&
                         (!avm_write || (wr_accept_c && !wr_last_c));
    assign recv_next_c = rd_recv + LEN_W'(fifo_push_c);
    assign rem_after_c = remaining - n_words;
    assign wr_data_c   = copy_mode ? fifo_rd_data_c : fill_val;

    tetris_nios_mover_fifo #(
        .DEPTH  (CHUNK),
        .DATA_W (16)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push_c),
        .pop       (fifo_pop_c),
        .wr_data   (avm_readdata),
        .rd_data_c (fifo_rd_data_c),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            cmd_ready     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
            copy_mode     <= 1'b0;
            src_addr      <= '0;
            dst_addr      <= '0;
            remaining     <= '0;
            n_words       <= '0;
            rd_issued     <= '0;
            rd_recv       <= '0;
            wr_cnt        <= '0;
            fill_val      <= '0;
        end else begin
            if (fifo_push_c)
                rd_recv <= recv_next_c;

            unique case (state)
                ST_IDLE: begin
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        copy_mode <= cmd_copy;
                        src_addr  <= cmd_src;
                        dst_addr  <= cmd_dst;
                        remaining <= cmd_len;
                        fill_val  <= cmd_fill;
                        rd_issued <= '0;
                        rd_recv   <= '0;
                        wr_cnt    <= '0;
                        if (cmd_len == '0) begin
                            state <= ST_FIN;
                        end else if (cmd_copy) begin
                            n_words     <= chunk_n(cmd_len);
                            avm_read    <= 1'b1;
                            avm_address <= to_bus(cmd_src);
                            state       <= ST_RD;
                        end else begin
                            n_words <= cmd_len;
                            state   <= ST_WR;
                        end
                    end
                end

                ST_RD: begin
                    if (rd_accept_c) begin
                        src_addr  <= src_addr + ADR_ONE;
                        rd_issued <= rd_issued + LEN_ONE;
                        if (rd_last_c) begin
                            avm_read <= 1'b0;
                            state    <= ST_RD_WAIT;
                        end else begin
                            avm_address <= to_bus(src_addr + ADR_ONE);
                        end
                    end
                end

                ST_RD_WAIT: begin
                    if (recv_next_c == n_words)
                        state <= ST_WR;
                end

                // First WR cycle only loads the bus; each accepted beat loads the next one.
                ST_WR: begin
                    if (!avm_write) begin
                        avm_write     <= 1'b1;
                        avm_address   <= to_bus(dst_addr);
                        avm_writedata <= wr_data_c;
                    end else if (wr_accept_c) begin
                        dst_addr <= dst_addr + ADR_ONE;
                        wr_cnt   <= wr_cnt + LEN_ONE;
                        if (wr_last_c) begin
                            avm_write <= 1'b0;
                            wr_cnt    <= '0;
                            rd_issued <= '0;
                            rd_recv   <= '0;
                            if (copy_mode && (rem_after_c != '0)) begin
                                remaining   <= rem_after_c;
                                n_words     <= chunk_n(rem_after_c);
                                avm_read    <= 1'b1;
                                avm_address <= to_bus(src_addr);
                                state       <= ST_RD;
                            end else begin
                                state <= ST_FIN;
                            end
                        end else begin
                            avm_address   <= to_bus(dst_addr + ADR_ONE);
                            avm_writedata <= wr_data_c;
                        end
                    end
                end

                ST_FIN: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // All of a chunk's reads complete before its writes, so the buffer can neither starve nor overflow.
    always_ff @(posedge clk) begin
        if (!reset && (state == ST_WR) && copy_mode && !avm_write)
            assert (!fifo_empty);
        if (!reset && fifo_push_c)
            assert (fifo_count != CNT_W'(CHUNK));
    end

endmodule

// File: tb/tb_tetris_nios_block_mover.sv
// Scoreboard bench: RAM slave model plus a chunk-level reference of fill/copy semantics.
module tb_tetris_nios_block_mover;

    localparam int unsigned WADDR_W   = 17;
    localparam int unsigned CHUNK     = 8;
    localparam int unsigned LEN_W     = 17;
    localparam int unsigned MEM_WORDS = 1 << WADDR_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_copy;
    logic [WADDR_W-1:0] cmd_src;
    logic [WADDR_W-1:0] cmd_dst;
    logic [LEN_W-1:0]   cmd_len;
    logic [15:0]        cmd_fill;
    logic               busy;
    logic               done;
    logic [WADDR_W:0]   avm_address;
    logic               avm_read;
    logic               avm_write;
    logic [15:0]        avm_writedata;
    logic [1:0]         avm_byteenable;
    logic               avm_waitrequest   = 1'b0;
    logic [15:0]        avm_readdata      = 16'h0;
    logic               avm_readdatavalid = 1'b0;

    tetris_nios_block_mover #(
        .WADDR_W (WADDR_W),
        .CHUNK   (CHUNK),
        .LEN_W   (LEN_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_copy          (cmd_copy),
        .cmd_src           (cmd_src),
        .cmd_dst           (cmd_dst),
        .cmd_len           (cmd_len),
        .cmd_fill          (cmd_fill),
        .busy              (busy),
        .done              (done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             wr;
        logic [WADDR_W:0] addr;
        logic [15:0]      data;
    } op_t;

    typedef struct packed {
        int          due;
        logic [15:0] data;
    } beat_t;

    op_t         exp_q[$];
    beat_t       rq[$];
    beat_t       beat;
    op_t         e;
    logic [15:0] ram   [MEM_WORDS];
    logic [15:0] model [MEM_WORDS];
    int          total = 0;
    int          bad = 0;
    int          exp_done = 0;
    int          cyc = 0;
    int          lat = 1;
    int          rd_acc = 0;
    bit          rand_wait = 1'b0;
    bit          mon_en = 1'b1;

    // RAM slave: random stalls, fixed read latency, multiple reads in flight.
    always @(posedge clk) begin
        cyc++;
        if (avm_write && !avm_waitrequest)
            ram[avm_address[WADDR_W:1]] = avm_writedata;
        if (avm_read && !avm_waitrequest) begin
            rd_acc++;
            rq.push_back('{due: cyc + lat - 1, data: ram[avm_address[WADDR_W:1]]});
        end
        if (rq.size() != 0 && rq[0].due <= cyc) begin
            beat = rq.pop_front();
            avm_readdatavalid <= 1'b1;
            avm_readdata      <= beat.data;
        end else begin
            avm_readdatavalid <= 1'b0;
        end
        avm_waitrequest <= rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    logic             prev_stall = 1'b0;
    logic             prev_done = 1'b0;
    logic             prev_rd, prev_wr;
    logic [WADDR_W:0] prev_addr;
    logic [15:0]      prev_wd;

    // Monitor: bus ops and done pulses against the scoreboard, plus stall/exclusivity rules.
    always @(negedge clk) begin
        if (!reset) begin
            if (avm_read || avm_write) begin
                total++;
                if (avm_read && avm_write) begin
                    bad++;
                    $display("FAIL bus_excl read=%0b write=%0b required at most one", avm_read, avm_write);
                end
            end
            if (prev_stall) begin
                total++;
                if ({avm_read, avm_write, avm_address, avm_writedata} !== {prev_rd, prev_wr, prev_addr, prev_wd}) begin
                    bad++;
                    $display("FAIL stall_hold actual rd=%0b wr=%0b addr=0x%0h wd=0x%0h required rd=%0b wr=%0b addr=0x%0h wd=0x%0h",
                             avm_read, avm_write, avm_address, avm_writedata, prev_rd, prev_wr, prev_addr, prev_wd);
                end
            end
            if (mon_en && (avm_read || avm_write) && !avm_waitrequest) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_op wr=%0b addr=0x%0h required no bus op", avm_write, avm_address);
                end else begin
                    e = exp_q.pop_front();
                    if (e.wr !== avm_write || e.addr !== avm_address ||
                        (e.wr && e.data !== avm_writedata) || avm_byteenable !== 2'b11) begin
                        bad++;
                        $display("FAIL bus_op actual wr=%0b addr=0x%0h data=0x%0h be=%0b required wr=%0b addr=0x%0h data=0x%0h be=11",
                                 avm_write, avm_address, avm_writedata, avm_byteenable, e.wr, e.addr, e.data);
                    end
                end
            end
            if (done) begin
                total++;
                if (exp_done == 0 || prev_done) begin
                    bad++;
                    $display("FAIL done_pulse actual done=1 prev=%0b required expected_pending=%0d single cycle", prev_done, exp_done);
                end
                if (exp_done > 0)
                    exp_done--;
            end
        end
        prev_stall = !reset && (avm_read || avm_write) && avm_waitrequest;
        prev_done  = !reset && done;
        prev_rd    = avm_read;
        prev_wr    = avm_write;
        prev_addr  = avm_address;
        prev_wd    = avm_writedata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference: forward, chunk-at-a-time copy (all reads of a chunk before its writes), or plain fill.
    task automatic push_expected(input bit copy, input logic [WADDR_W-1:0] src, input logic [WADDR_W-1:0] dst,
                                 input logic [LEN_W-1:0] len, input logic [15:0] fill);
        logic [15:0]        buf_w [CHUNK];
        logic [WADDR_W-1:0] s, d;
        int                 rem, n;
        s = src;
        d = dst;
        rem = int'(len);
        if (copy) begin
            while (rem > 0) begin
                n = (rem < int'(CHUNK)) ? rem : int'(CHUNK);
                for (int i = 0; i < n; i++) begin
                    buf_w[i] = model[s];
                    exp_q.push_back('{wr: 1'b0, addr: {s, 1'b0}, data: 16'h0});
                    s = s + 1'b1;
                end
                for (int i = 0; i < n; i++) begin
                    model[d] = buf_w[i];
                    exp_q.push_back('{wr: 1'b1, addr: {d, 1'b0}, data: buf_w[i]});
                    d = d + 1'b1;
                end
                rem -= n;
            end
        end else begin
            for (int i = 0; i < rem; i++) begin
                model[d] = fill;
                exp_q.push_back('{wr: 1'b1, addr: {d, 1'b0}, data: fill});
                d = d + 1'b1;
            end
        end
        exp_done++;
    endtask

    task automatic run_cmd(input bit copy, input logic [WADDR_W-1:0] src, input logic [WADDR_W-1:0] dst,
                           input logic [LEN_W-1:0] len, input logic [15:0] fill, input bit zero_chk);
        int                 n;
        logic [WADDR_W-1:0] a;
        push_expected(copy, src, dst, len, fill);
        @(negedge clk);
        cmd_copy  = copy;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_len   = len;
        cmd_fill  = fill;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("ready_low_after_accept", 32'(cmd_ready), 32'd0);
        chk("busy_after_accept", 32'(busy), 32'd1);
        if (zero_chk) begin
            chk("zero_done_early", 32'(done), 32'd0);
            @(negedge clk);
            chk("zero_done_pulse", 32'(done), 32'd1);
            @(negedge clk);
            chk("zero_ready_back", 32'(cmd_ready), 32'd1);
        end else begin
            n = 0;
            while (!cmd_ready && n < 3000) begin
                @(negedge clk);
                n++;
            end
            chk("cmd_complete", 32'(cmd_ready), 32'd1);
        end
        chk("ops_left", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(exp_done), 32'd0);
        exp_q.delete();
        exp_done = 0;
        for (int i = -1; i <= int'(len); i++) begin
            a = dst + WADDR_W'(i);
            chk($sformatf("ram[0x%0h]", a), 32'(ram[a]), 32'(model[a]));
        end
    endtask

    initial begin
        int n;
        int base;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_copy  = 1'b0;
        cmd_src   = '0;
        cmd_dst   = '0;
        cmd_len   = '0;
        cmd_fill  = '0;
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            ram[i]   = 16'(i * 3 + 1);
            model[i] = ram[i];
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_read", 32'(avm_read), 32'd0);
        chk("rst_write", 32'(avm_write), 32'd0);
        chk("rst_address", 32'(avm_address), 32'd0);
        chk("rst_writedata", 32'(avm_writedata), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_cmd(1'b0, 17'h0, 17'h00100, 17'd5, 16'hA5A5, 1'b0);
        run_cmd(1'b1, 17'h0, 17'h00400, 17'd20, 16'h0, 1'b0);
        rand_wait = 1'b1;
        run_cmd(1'b1, 17'h00040, 17'h00800, 17'd13, 16'h0, 1'b0);
        rand_wait = 1'b0;
        run_cmd(1'b1, 17'h00010, 17'h00020, 17'd0, 16'h0, 1'b1);
        run_cmd(1'b0, 17'h0, 17'h1FFFE, 17'd4, 16'h1234, 1'b0);

        // Reset in the middle of a chunk read with three reads outstanding.
        lat    = 4;
        mon_en = 1'b0;
        @(negedge clk);
        cmd_copy  = 1'b1;
        cmd_src   = 17'h00020;
        cmd_dst   = 17'h00900;
        cmd_len   = 17'd16;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        base = rd_acc;
        n = 0;
        while ((rd_acc - base) < 3 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reads_before_reset", 32'(rd_acc - base), 32'd3);
        reset = 1'b1;
        #1;
        chk("async_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        chk("async_read", 32'(avm_read), 32'd0);
        chk("async_write", 32'(avm_write), 32'd0);
        chk("async_address", 32'(avm_address), 32'd0);
        chk("async_writedata", 32'(avm_writedata), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("idle_after_reset", 32'({cmd_ready, busy}), 32'b10);
        mon_en = 1'b1;
        lat    = 1;
        run_cmd(1'b0, 17'h0, 17'h00A00, 17'd6, 16'h5A5A, 1'b0);
        run_cmd(1'b1, 17'h00030, 17'h00980, 17'd9, 16'h0, 1'b0);

        for (int t = 0; t < 10; t++) begin
            rand_wait = 1'($urandom_range(0, 1));
            lat       = int'($urandom_range(1, 3));
            run_cmd(1'($urandom_range(0, 1)),
                    17'($urandom_range(0, 'h7FFF)),
                    17'($urandom_range('h10000, 'h1FFF0)),
                    17'($urandom_range(0, 40)),
                    16'($urandom),
                    1'b0);
        end
        rand_wait = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
